// File: rtl/nbody_pkg.sv
// Shared select codes, field and state enums for the n-body host front end,
// used by the host interface, the engine and the bench.
package nbody_pkg;

    localparam int BODY_ADDR_WIDTH = 9;
    localparam int SEL_WIDTH       = 7;
    localparam int MAX_BODIES      = 512;
    localparam int NUM_FIELDS      = 5;

    localparam logic [SEL_WIDTH-1:0] GO            = 7'h00;
    localparam logic [SEL_WIDTH-1:0] READ          = 7'h01;
    localparam logic [SEL_WIDTH-1:0] N_BODIES      = 7'h02;
    localparam logic [SEL_WIDTH-1:0] GAP           = 7'h03;
    localparam logic [SEL_WIDTH-1:0] X_SEL_LOWER   = 7'h04;
    localparam logic [SEL_WIDTH-1:0] X_SEL_UPPER   = 7'h05;
    localparam logic [SEL_WIDTH-1:0] Y_SEL_LOWER   = 7'h06;
    localparam logic [SEL_WIDTH-1:0] Y_SEL_UPPER   = 7'h07;
    localparam logic [SEL_WIDTH-1:0] M_SEL_LOWER   = 7'h08;
    localparam logic [SEL_WIDTH-1:0] M_SEL_UPPER   = 7'h09;
    localparam logic [SEL_WIDTH-1:0] VX_SEL_LOWER  = 7'h10;
    localparam logic [SEL_WIDTH-1:0] VX_SEL_UPPER  = 7'h11;
    localparam logic [SEL_WIDTH-1:0] VY_SEL_LOWER  = 7'h12;
    localparam logic [SEL_WIDTH-1:0] VY_SEL_UPPER  = 7'h13;
    localparam logic [SEL_WIDTH-1:0] DONE          = 7'h40;
    localparam logic [SEL_WIDTH-1:0] READ_X        = 7'h41;
    localparam logic [SEL_WIDTH-1:0] READ_Y        = 7'h42;

    // Enum value doubles as the mem_we bit position of the field.
    typedef enum logic [2:0] {
        FLD_X  = 3'd0,
        FLD_Y  = 3'd1,
        FLD_VX = 3'd2,
        FLD_VY = 3'd3,
        FLD_M  = 3'd4
    } field_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE_ST = 2'd2
    } state_e;

    function automatic logic [SEL_WIDTH-1:0] lower_sel(input logic [2:0] f);
        case (f)
            FLD_X:   lower_sel = X_SEL_LOWER;
            FLD_Y:   lower_sel = Y_SEL_LOWER;
            FLD_VX:  lower_sel = VX_SEL_LOWER;
            FLD_VY:  lower_sel = VY_SEL_LOWER;
            default: lower_sel = M_SEL_LOWER;
        endcase
    endfunction

    function automatic logic [SEL_WIDTH-1:0] upper_sel(input logic [2:0] f);
        case (f)
            FLD_X:   upper_sel = X_SEL_UPPER;
            FLD_Y:   upper_sel = Y_SEL_UPPER;
            FLD_VX:  upper_sel = VX_SEL_UPPER;
            FLD_VY:  upper_sel = VY_SEL_UPPER;
            default: upper_sel = M_SEL_UPPER;
        endcase
    endfunction

endpackage

// File: rtl/nbody_half_stager.sv
// One field's lower-half stage; commit data is {upper half, stage}, combinational.
// The stage clears on every commit so a lone upper write carries a zero lower half.
module nbody_half_stager
    import nbody_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_wr_i,
    input  logic        hi_wr_i,
    input  logic [31:0] half_i,
    output logic [63:0] commit_dat_o
);

    logic [31:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (hi_wr_i) begin
            stage_d = '0;
        end else if (lo_wr_i) begin
            stage_d = half_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign commit_dat_o = {half_i, stage_q};

endmodule

// File: rtl/nbody_host_if.sv
// Host bus responder: control registers, 32->64 bit body-memory write assembly, result reads.
// Writes strobe mem_* one cycle after acceptance; reads return 2 edges later; always ready.
module nbody_host_if
    import nbody_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [15:0]                addr,
    input  logic [63:0]                writedata,
    output logic [63:0]                readdata,
    output logic                       start,
    output logic                       run,
    output logic                       freeze,
    output logic [9:0]                 n_bodies,
    output logic [31:0]                gap,
    input  logic                       done,
    output logic [NUM_FIELDS-1:0]      mem_we,
    output logic [BODY_ADDR_WIDTH-1:0] mem_waddr,
    output logic [63:0]                mem_wdata,
    output logic [BODY_ADDR_WIDTH-1:0] res_raddr,
    input  logic [63:0]                res_rdata_x,
    input  logic [63:0]                res_rdata_y
);

    logic [SEL_WIDTH-1:0]       sel;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic [31:0]                wd;
    logic                       unused_wdata;
    logic                       wr_acc, rd_acc, busy, mem_sel;
    logic                       go_rise, go_clear;

    logic                       go_q, go_d;
    logic                       freeze_q, freeze_d;
    logic [9:0]                 nb_q, nb_d;
    logic [31:0]                gap_q, gap_d;
    logic                       err_q, err_d;
    logic                       start_q, start_d;
    logic [NUM_FIELDS-1:0]      we_q, we_d;
    logic [BODY_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [63:0]                wdata_q, wdata_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [SEL_WIDTH-1:0]       rd_sel_q, rd_sel_d;
    logic [63:0]                readdata_q, readdata_d;
    state_e                     state_q, state_d;

    logic [NUM_FIELDS-1:0]      lo_hit, hi_hit, lo_wr, hi_wr;
    logic [63:0]                commit_dat [NUM_FIELDS];

    assign sel          = addr[15:9];
    assign idx          = addr[8:0];
    assign wd           = writedata[31:0];
    assign unused_wdata = ^writedata[63:32];

    // A simultaneous read and write performs only the write.
    assign wr_acc   = chipselect & write;
    assign rd_acc   = chipselect & read & ~write;
    assign busy     = go_q & ~done;
    assign go_rise  = wr_acc & (sel == GO) & wd[0] & ~go_q;
    assign go_clear = wr_acc & (sel == GO) & ~wd[0];

    always_comb begin
        lo_hit = '0;
        hi_hit = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            lo_hit[f] = (sel == lower_sel(3'(f)));
            hi_hit[f] = (sel == upper_sel(3'(f)));
        end
    end

    assign mem_sel = |(lo_hit | hi_hit);
    assign lo_wr   = (wr_acc & ~busy) ? lo_hit : '0;
    assign hi_wr   = (wr_acc & ~busy) ? hi_hit : '0;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_stage
        nbody_half_stager u_stager (
            .clk          (clk),
            .rst          (rst),
            .lo_wr_i      (lo_wr[g]),
            .hi_wr_i      (hi_wr[g]),
            .half_i       (wd),
            .commit_dat_o (commit_dat[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_rise) state_d = RUNNING;
            RUNNING: if (go_clear) state_d = IDLE;
                     else if (done) state_d = DONE_ST;
            DONE_ST: if (go_clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        go_d       = go_q;
        freeze_d   = freeze_q;
        nb_d       = nb_q;
        gap_d      = gap_q;
        err_d      = err_q;
        start_d    = go_rise;
        we_d       = hi_wr;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rd_pend_d  = rd_acc;
        rd_sel_d   = rd_acc ? sel : rd_sel_q;
        readdata_d = readdata_q;

        if (wr_acc) begin
            case (sel)
                GO: begin
                    go_d = wd[0];
                    if (!wd[0]) err_d = 1'b0;
                end
                READ:     freeze_d = wd[0];
                N_BODIES: nb_d = (wd > 32'(MAX_BODIES)) ? 10'(MAX_BODIES) : wd[9:0];
                GAP:      gap_d = wd;
                default:  ;
            endcase
            if (mem_sel && busy) err_d = 1'b1;
        end

        if (|hi_wr) begin
            waddr_d = idx;
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (hi_wr[f]) wdata_d = commit_dat[f];
            end
        end

        // Result RAM output is valid now for the index presented last cycle.
        if (rd_pend_q) begin
            case (rd_sel_q)
                DONE:    readdata_d = {62'b0, err_q, done};
                READ_X:  readdata_d = freeze_q ? res_rdata_x : 64'b0;
                READ_Y:  readdata_d = freeze_q ? res_rdata_y : 64'b0;
                default: readdata_d = 64'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q       <= 1'b0;
            freeze_q   <= 1'b0;
            nb_q       <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            we_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_sel_q   <= '0;
            readdata_q <= '0;
            state_q    <= IDLE;
        end else begin
            go_q       <= go_d;
            freeze_q   <= freeze_d;
            nb_q       <= nb_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            start_q    <= start_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_sel_q   <= rd_sel_d;
            readdata_q <= readdata_d;
            state_q    <= state_d;
        end
    end

    assign readdata  = readdata_q;
    assign start     = start_q;
    assign run       = go_q;
    assign freeze    = freeze_q;
    assign n_bodies  = nb_q;
    assign gap       = gap_q;
    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign res_raddr = idx;

endmodule

// File: tb/tb_nbody_host_if.sv
// Directed bench for nbody_host_if: commits and reads are scored against queued expectations.
module tb_nbody_host_if;
    import nbody_pkg::*;

    typedef struct packed {
        logic [4:0]  we;
        logic [8:0]  addr;
        logic [63:0] data;
    } commit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        chipselect, write, read, done;
    logic [15:0] addr;
    logic [63:0] writedata, readdata, mem_wdata, res_rdata_x, res_rdata_y;
    logic        start, run, freeze;
    logic [9:0]  n_bodies;
    logic [31:0] gap;
    logic [4:0]  mem_we;
    logic [8:0]  mem_waddr, res_raddr;

    int          n_tests = 0;
    int          n_fail  = 0;
    commit_t     exp_q[$];
    logic [63:0] rd_q[$];

    nbody_host_if dut (
        .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
        .addr(addr), .writedata(writedata), .readdata(readdata), .start(start),
        .run(run), .freeze(freeze), .n_bodies(n_bodies), .gap(gap), .done(done),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .res_raddr(res_raddr), .res_rdata_x(res_rdata_x), .res_rdata_y(res_rdata_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every strobe seen must match the oldest queued commit.
    always @(negedge clk) begin
        if (mem_we !== 5'b0) begin
            commit_t got, exp;
            got = '{we: mem_we, addr: mem_waddr, data: mem_wdata};
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("commit", 128'(got), 128'(exp));
        end
    end

    task automatic wr(input logic [6:0] s, input logic [8:0] i, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        addr = {s, i}; writedata = {32'hA5A5_A5A5, d};
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] s, input logic [8:0] i,
                          input logic [63:0] exp);
        logic [63:0] e;
        rd_q.push_back(exp);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; addr = {s, i};
        #1 chk({tag, " raddr"}, 128'(res_raddr), 128'(i));
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        e = rd_q.pop_front();
        chk(tag, 128'(readdata), 128'(e));
    endtask

    task automatic push(input logic [4:0] we, input logic [8:0] a, input logic [63:0] d);
        exp_q.push_back('{we: we, addr: a, data: d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0; done = 1'b0;
        addr = '0; writedata = '0; res_rdata_x = '0; res_rdata_y = '0;
        repeat (2) @(negedge clk);
        chk("rst readdata", 128'(readdata), 128'(0));
        chk("rst ctrl", 128'({start, run, freeze}), 128'(0));
        chk("rst mem_we", 128'(mem_we), 128'(0));
        chk("rst waddr/wdata", 128'({mem_waddr, mem_wdata}), 128'(0));
        chk("rst nb/gap", 128'({n_bodies, gap}), 128'(0));
        rst = 1'b0;

        // Half-word assembly and stage behaviour
        wr(X_SEL_LOWER, 9'd3, 32'h0);
        push(5'b00001, 9'd3, 64'h3FF0_0000_0000_0000);
        wr(X_SEL_UPPER, 9'd3, 32'h3FF0_0000);
        @(negedge clk);
        chk("strobe width", 128'(mem_we), 128'(0));
        push(5'b01000, 9'd0, 64'h4024_0000_0000_0000);
        wr(VY_SEL_UPPER, 9'd0, 32'h4024_0000);
        wr(Y_SEL_LOWER, 9'd5, 32'h1);
        push(5'b10000, 9'd5, 64'h3FF0_0000_0000_0000);
        wr(M_SEL_UPPER, 9'd5, 32'h3FF0_0000);
        wr(X_SEL_LOWER, 9'd7, 32'hDEAD_BEEF);
        push(5'b00001, 9'd9, 64'h4000_0000_DEAD_BEEF);
        wr(X_SEL_UPPER, 9'd9, 32'h4000_0000);
        push(5'b00001, 9'd9, 64'h0000_0001_0000_0000);
        wr(X_SEL_UPPER, 9'd9, 32'h1);

        // Back-to-back commits; Y still holds its earlier lower half
        push(5'b00001, 9'd4, 64'h0000_000A_0000_0000);
        push(5'b00010, 9'd4, 64'h0000_000B_0000_0001);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; addr = {X_SEL_UPPER, 9'd4}; writedata = 64'hA;
        @(negedge clk);
        addr = {Y_SEL_UPPER, 9'd4}; writedata = 64'hB;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        repeat (2) @(negedge clk);

        // Control registers and start pulse
        wr(N_BODIES, 9'd0, 32'd25);
        chk("n_bodies 25", 128'(n_bodies), 128'(25));
        wr(N_BODIES, 9'd0, 32'd1000);
        chk("n_bodies 1000", 128'(n_bodies), 128'(512));
        wr(N_BODIES, 9'd0, 32'd511);
        chk("n_bodies 511", 128'(n_bodies), 128'(511));
        wr(N_BODIES, 9'd0, 32'd513);
        chk("n_bodies 513", 128'(n_bodies), 128'(512));
        wr(GAP, 9'd0, 32'd6);
        chk("gap 6", 128'(gap), 128'(6));
        wr(GO, 9'd0, 32'd1);
        chk("start pulse", 128'({start, run}), 128'(2'b11));
        @(negedge clk);
        chk("start falls", 128'({start, run}), 128'(2'b01));
        wr(GO, 9'd0, 32'd1);
        chk("no re-pulse", 128'({start, run}), 128'(2'b01));

        // Busy lockout
        wr(M_SEL_UPPER, 9'd2, 32'h1234_5678);
        chk("busy drop", 128'(mem_we), 128'(0));
        wr(X_SEL_LOWER, 9'd1, 32'h77);
        rd_chk("done err", DONE, 9'd0, 64'h2);
        wr(GO, 9'd0, 32'd0);
        chk("run low", 128'({start, run}), 128'(0));
        rd_chk("done clr", DONE, 9'd0, 64'h0);
        push(5'b00001, 9'd1, 64'h0000_0002_0000_0000);
        wr(X_SEL_UPPER, 9'd1, 32'h2);

        // Running but engine done: writes allowed
        done = 1'b1;
        wr(GO, 9'd0, 32'd1);
        push(5'b00100, 9'd8, 64'h0000_0005_0000_0000);
        wr(VX_SEL_UPPER, 9'd8, 32'h5);
        rd_chk("done bit", DONE, 9'd0, 64'h1);
        wr(GO, 9'd0, 32'd0);

        // Result readback
        wr(READ, 9'd0, 32'd1);
        chk("freeze", 128'(freeze), 128'(1));
        res_rdata_x = 64'h4034_0000_0000_0000;
        res_rdata_y = 64'h4059_0000_0000_0000;
        rd_chk("res x", READ_X, 9'd2, 64'h4034_0000_0000_0000);
        rd_chk("res y", READ_Y, 9'd2, 64'h4059_0000_0000_0000);
        rd_chk("undef sel", 7'h50, 9'd2, 64'h0);
        wr(READ, 9'd0, 32'd0);
        rd_chk("done pre", DONE, 9'd0, 64'h1);
        rd_chk("res x unfrozen", READ_X, 9'd2, 64'h0);

        // Reset with an upper write in flight
        wr(GAP, 9'd0, 32'd9);
        wr(READ, 9'd0, 32'd1);
        wr(GO, 9'd0, 32'd1);
        wr(X_SEL_LOWER, 9'd0, 32'h55);
        rd_chk("pre rst", DONE, 9'd0, 64'h1);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; addr = {X_SEL_UPPER, 9'd6}; writedata = 64'h3;
        rst = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        chk("rst mid mem_we", 128'(mem_we), 128'(0));
        chk("rst mid ctrl", 128'({start, run, freeze}), 128'(0));
        chk("rst mid regs", 128'({readdata, gap, n_bodies}), 128'(0));
        chk("rst mid wr", 128'({mem_waddr, mem_wdata}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        push(5'b00001, 9'd6, 64'h0000_0003_0000_0000);
        wr(X_SEL_UPPER, 9'd6, 32'h3);

        // Read/write collision
        rd_chk("pre coll", DONE, 9'd0, 64'h1);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; addr = {GAP, 9'd0}; writedata = 64'd7;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        @(negedge clk);
        chk("coll gap", 128'(gap), 128'(7));
        chk("coll readdata", 128'(readdata), 128'(1));

        repeat (3) @(negedge clk);
        chk("sb drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nbody_host_if.md
# nbody_host_if

Host-side register/memory front end for the n-body accelerator: the Avalon-MM style responder that receives the host's 32-bit half-word writes, assembles them into 64-bit doubles for the body memories, holds the control registers, and returns result positions on reads. It sits between the HPS bridge and the force/integration engine. It owns the whole protocol decode, so the engine sees only clean 64-bit write strobes, a start pulse and a results read port.

## Interface
- BODY_ADDR_WIDTH, 9: body index width, `addr[8:0]`; max bodies is 2^9 = 512.
- SEL_WIDTH, 7: select code width, `addr[15:9]`.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- chipselect  in  1  bus select; nothing happens when low
- write  in  1  write strobe, qualified by chipselect
- read  in  1  read strobe, qualified by chipselect
- addr  in  16  {select[6:0], body index[8:0]}
- writedata  in  64  only [31:0] is used
- readdata  out  64  read response
- start  out  1  one-cycle pulse to the engine
- run  out  1  level copy of the GO register
- freeze  out  1  level copy of the READ register; engine holds its state while high
- n_bodies  out  10  body count, clamped to 512
- gap  out  32  integration steps per result snapshot
- done  in  1  engine finished the current run
- mem_we  out  5  one-hot write enable: bit0 X, bit1 Y, bit2 VX, bit3 VY, bit4 M
- mem_waddr  out  9  body index for the write
- mem_wdata  out  64  assembled double
- res_raddr  out  9  results read index
- res_rdata_x  in  64  result X; valid one cycle after res_raddr
- res_rdata_y  in  64  result Y; valid one cycle after res_raddr

## Operation
- **Control registers** (write `writedata[31:0]`):
  - GO = 0x00: writes bit0.
  - READ = 0x01: writes bit0.
  - N_BODIES = 0x02: values above 512 store 512.
  - GAP = 0x03: stores the full 32 bits.
- **Memory selects.** Lower/upper pairs: X 0x04/0x05, Y 0x06/0x07, M 0x08/0x09, VX 0x10/0x11, VY 0x12/0x13.
  - A lower write loads that field's 32-bit stage.
  - An upper write commits {writedata[31:0], stage} to mem_waddr = `addr[8:0]`, pulsing the matching mem_we bit for 1 cycle. The stage then clears to 0.
  - An upper write with no prior lower write commits a zero lower half.
  - The upper write's index is the one used, even if the lower write targeted a different index.
- **Start pulse.** It fires on a GO 0→1 transition only. Rewriting 1 while GO is already 1 does not re-pulse.
- **Busy state.** Busy = run & ~done.
  - Memory-select writes while busy are dropped and set a sticky `err` bit.
  - `err` clears when GO is written 0.
- **Read selects** (1-cycle latency):
  - DONE = 0x40: readdata = {62'b0, err, done}.
  - 0x41: returns the 64-bit result X of `addr[8:0]`.
  - 0x42: returns the 64-bit result Y of `addr[8:0]`.
  - 0x41/0x42 return 0 unless freeze = 1.
  - Undefined selects return 0 and, on write, are ignored.
- **Read/write collision.** read & write in the same cycle: the write is performed and the read is ignored; readdata holds its previous value.
- **State machine** on `run` / `done`: IDLE → (GO 0→1) RUNNING → (done) DONE_ST → (GO written 0) IDLE.
  - Writing GO 0 in RUNNING returns to IDLE; the engine aborts on run low.

## Timing
- **Reset values.** All registers clear asynchronously: GO, READ, n_bodies, gap, stages, err, state = IDLE. Outputs start, run, freeze, mem_we, readdata = 0; mem_waddr, mem_wdata, res_raddr = 0.
- **Write path.** A write accepted at edge t produces mem_we/mem_waddr/mem_wdata as registered outputs valid for exactly cycle t+1. Back-to-back commits therefore give consecutive single-cycle strobes.
- **Start pulse.** Registered; high during the cycle after the GO-writing edge. run rises in the same cycle.
- **Read path.** res_raddr is combinational from `addr[8:0]`. The select is registered at edge t. readdata is updated at edge t+1 from the registered select and the res_rdata inputs, and is held until the next read.
- **Reset mid-operation.** A pending commit or read is cancelled, no strobe or start is emitted, and the next accepted transaction proceeds normally.

## Structure
- **Package `nbody_pkg`:** select-code localparams (GO … VY_SEL_UPPER, DONE, READ_X, READ_Y), BODY_ADDR_WIDTH, SEL_WIDTH, MAX_BODIES, a field enum {X, Y, VX, VY, M}, and a state enum {IDLE, RUNNING, DONE_ST}. Shared with the engine and the bench.
- **Sub-module `nbody_half_stager`:** one field's 32-bit stage and commit logic, instantiated 5×; the top level muxes the commits into mem_*.

## Test plan
- **Half-word assembly:** write X lower @ idx 3 with 0x00000000, then X upper with 0x3FF00000 → one-cycle mem_we = 5'b00001, mem_waddr = 3, mem_wdata = 0x3FF0000000000000 (1.0).
- **Missing lower, stage clearing:** a VY upper-only write of 0x40240000 @ idx 0 → mem_wdata = 0x4024000000000000; then Y lower 0x1, M upper → M commit lower half = 0, not 0x1.
- **Control registers and start:** N_BODIES = 25 → n_bodies = 25; N_BODIES = 1000 → 512; GAP = 6; GO = 1 → one start pulse; GO = 1 again → no pulse.
- **Busy lockout:** during RUNNING (done = 0), a mass upper write → no mem_we, DONE read = 0x2. After GO = 0, DONE read = 0x0.
- **Result readback:** done = 1, READ = 1, read 0x41 @ idx 2 with res_rdata_x = 0x4034000000000000 → readdata equals it one cycle later. With READ = 0 the same read → 0.
- **Reset and collision:** rst asserted the cycle after an upper write → no strobe, all outputs 0. read & write together on GAP = 7 → gap = 7, readdata unchanged.
